// File: rtl/cia_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cia_pkg - shared ICR bit positions and types for the 8520 CIA blocks  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cia_pkg;

  localparam int CIA_ICR_TA     = 0;
  localparam int CIA_ICR_TB     = 1;
  localparam int CIA_ICR_ALRM   = 2;
  localparam int CIA_ICR_SP     = 3;
  localparam int CIA_ICR_FLG    = 4;
  localparam int ICR_SETCLR_BIT = 7;
  localparam int ICR_W          = 5;

  typedef logic [ICR_W-1:0] icr_t;

endpackage
`default_nettype wire

// File: rtl/cia_flag_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cia_flag_edge - FLAG pin synchroniser and falling-edge detector       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cia_flag_edge #(
  parameter int FLAG_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clk7_en,
  input  logic flag,
  output logic flg_pulse
);

  logic [FLAG_SYNC_STAGES-1:0] r_sync;
  logic                        r_hist;

  // Flops preset high so an idle (high) pin never looks like a falling edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {FLAG_SYNC_STAGES{1'b1}};
      r_hist <= 1'b1;
    end else if (clk7_en) begin
      r_sync <= {r_sync[FLAG_SYNC_STAGES-2:0], flag};
      r_hist <= r_sync[FLAG_SYNC_STAGES-1];
    end
  end

  assign flg_pulse = r_hist & ~r_sync[FLAG_SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cia_int.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cia_int - 8520 CIA interrupt control: ICR data/mask, read-clear, IRQ  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cia_int
  import cia_pkg::*;
#(
  parameter int FLAG_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic       wr,
  input  logic       rd,
  input  logic       icrs,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       ta,
  input  logic       tb,
  input  logic       alrm,
  input  logic       ser,
  input  logic       flag,
  output logic       irq
);

  icr_t r_icr;
  icr_t r_imr;
  logic r_irq;
  icr_t w_events;
  logic w_flg;
  logic w_rd_clr;
  logic w_mask_wr;
  logic w_unused_ok;

  cia_flag_edge #(
    .FLAG_SYNC_STAGES(FLAG_SYNC_STAGES)
  ) u_flag_edge (
    .clk       (clk),
    .reset     (reset),
    .clk7_en   (clk7_en),
    .flag      (flag),
    .flg_pulse (w_flg)
  );

  always_comb begin
    w_events               = '0;
    w_events[CIA_ICR_TA]   = ta;
    w_events[CIA_ICR_TB]   = tb;
    w_events[CIA_ICR_ALRM] = alrm;
    w_events[CIA_ICR_SP]   = ser;
    w_events[CIA_ICR_FLG]  = w_flg;
  end

  assign w_rd_clr    = icrs & ~wr & rd;
  assign w_mask_wr   = icrs & wr;
  assign w_unused_ok = ^data_in[6:5];

  // On a read-clear edge, events arriving in the same cycle survive the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_icr <= '0;
      r_imr <= '0;
      r_irq <= 1'b0;
    end else if (clk7_en) begin
      if (w_rd_clr) begin
        r_icr <= w_events;
        r_irq <= 1'b0;
      end else begin
        r_icr <= r_icr | w_events;
        r_irq <= |(r_icr & r_imr);
      end
      if (w_mask_wr) begin
        if (data_in[ICR_SETCLR_BIT])
          r_imr <= r_imr | data_in[ICR_W-1:0];
        else
          r_imr <= r_imr & ~data_in[ICR_W-1:0];
      end
    end
  end

  assign irq      = r_irq;
  assign data_out = (icrs & ~wr) ? {r_irq, 2'b00, r_icr} : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_cia_int.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cia_int - directed plus randomized checks of cia_int vs a model    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cia_int;

  localparam int S = 2;

  logic       clk;
  logic       reset;
  logic       clk7_en;
  logic       wr;
  logic       rd;
  logic       icrs;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ta;
  logic       tb;
  logic       alrm;
  logic       ser;
  logic       flag;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_icr;
  logic [4:0] m_imr;
  logic       m_irq;
  bit         qf[$];

  cia_int #(
    .FLAG_SYNC_STAGES(S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clk7_en  (clk7_en),
    .wr       (wr),
    .rd       (rd),
    .icrs     (icrs),
    .data_in  (data_in),
    .data_out (data_out),
    .ta       (ta),
    .tb       (tb),
    .alrm     (alrm),
    .ser      (ser),
    .flag     (flag),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_icr = '0;
    m_imr = '0;
    m_irq = 1'b0;
    qf    = {};
    repeat (S + 1) qf.push_front(1'b1);
  endtask

  // qf[j] holds the flag level seen at the (j+1)-th most recent enabled edge.
  task automatic tick();
    logic       rc;
    logic       fl_ev;
    logic [4:0] ev;
    @(posedge clk);
    if (!reset && clk7_en) begin
      fl_ev = (qf[S-1] == 1'b0) && (qf[S] == 1'b1);
      ev    = {fl_ev, ser, alrm, tb, ta};
      rc    = icrs & ~wr & rd;
      m_irq = rc ? 1'b0 : |(m_icr & m_imr);
      m_icr = rc ? ev : (m_icr | ev);
      if (icrs && wr)
        m_imr = data_in[7] ? (m_imr | data_in[4:0]) : (m_imr & ~data_in[4:0]);
      qf.push_front(flag);
      void'(qf.pop_back());
    end
    #1;
    chk("irq", {7'b0, irq}, {7'b0, m_irq});
    chk("dout", data_out, (icrs && !wr) ? {m_irq, 2'b00, m_icr} : 8'h00);
  endtask

  task automatic idle();
    clk7_en = 1'b1;
    ta = 1'b0; tb = 1'b0; alrm = 1'b0; ser = 1'b0;
    icrs = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'h00;
  endtask

  task automatic peek(input string tag, input logic [7:0] exp);
    icrs = 1'b1; wr = 1'b0; rd = 1'b0;
    #1;
    chk(tag, data_out, exp);
  endtask

  task automatic wr_icr(input logic [7:0] d);
    idle();
    icrs = 1'b1; wr = 1'b1; data_in = d;
    tick();
    idle();
  endtask

  task automatic rd_clr();
    idle();
    icrs = 1'b1; rd = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    flag  = 1'b1;
    idle();
    model_reset();
    tick();
    tick();
    reset = 1'b0;

    peek("rst_read", 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);

    idle(); tb = 1'b1; tick(); idle();
    peek("tb_evt", 8'h02);
    tick();
    chk("irq_unmasked", {7'b0, irq}, 8'h00);

    wr_icr(8'h82);
    chk("irq_wr_edge", {7'b0, irq}, 8'h00);
    tick();
    chk("irq_mask_set", {7'b0, irq}, 8'h01);
    peek("read_82", 8'h82);
    rd_clr();
    peek("read_clr", 8'h00);
    chk("irq_clr", {7'b0, irq}, 8'h00);

    wr_icr(8'h83);
    tb = 1'b1; tick(); idle(); tick();
    idle(); icrs = 1'b1; rd = 1'b1; ta = 1'b1; tick(); idle();
    peek("set_wins", 8'h01);
    tick();
    peek("set_wins_irq", 8'h81);

    rd_clr();
    wr_icr(8'h7F);
    wr_icr(8'h90);
    #3 flag = 1'b0;
    tick(); tick();
    peek("flg_early", 8'h00);
    tick();
    peek("flg_set", 8'h10);
    tick();
    peek("flg_irq", 8'h90);
    rd_clr();
    repeat (4) tick();
    peek("flg_hold", 8'h00);
    #2 flag = 1'b1;
    repeat (4) tick();
    peek("flg_rise", 8'h00);

    wr_icr(8'h9F);
    wr_icr(8'h03);
    ta = 1'b1; tb = 1'b1; tick(); idle(); tick();
    peek("mask_1c", 8'h03);
    chk("mask_1c_irq", {7'b0, irq}, 8'h00);

    idle(); alrm = 1'b1; ser = 1'b1; flag = 1'b0; tick(); idle();
    repeat (4) tick();
    peek("all_pending", 8'h9F);
    flag = 1'b1;
    repeat (3) tick();
    peek("hold_pending", 8'h9F);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_dout", data_out, 8'h00);
    chk("async_rst_irq", {7'b0, irq}, 8'h00);
    model_reset();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    peek("post_rst", 8'h00);
    idle(); ta = 1'b1; tick(); idle(); tick(); tick();
    chk("imr_after_rst", {7'b0, irq}, 8'h00);
    peek("post_rst_ta", 8'h01);

    for (int i = 0; i < 600; i++) begin
      clk7_en = ($urandom % 4) != 0;
      ta      = ($urandom % 6) == 0;
      tb      = ($urandom % 6) == 0;
      alrm    = ($urandom % 10) == 0;
      ser     = ($urandom % 8) == 0;
      icrs    = ($urandom % 2) == 0;
      wr      = ($urandom % 3) == 0;
      rd      = ($urandom % 4) == 0;
      data_in = 8'($urandom);
      if (($urandom % 6) == 0)
        flag = ~flag;
      if (($urandom % 150) == 0) begin
        reset = 1'b1;
        #1;
        chk("rnd_rst_irq", {7'b0, irq}, 8'h00);
        model_reset();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
